// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file port bundle (write port, two read ports, init status); macro REGFILE_BYPASS_EN is consumed by regfile_mp
interface regfile_mp_if #(
    parameter int DW = 8,
    parameter int AW = 5
) ();
    logic          rdy;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] DI;
    logic [AW-1:0] ra_a;
    logic [AW-1:0] ra_b;
    logic [DW-1:0] DO_a;
    logic [DW-1:0] DO_b;
    logic          init_done;

    modport master (
        output rdy, we, wa, DI, ra_a, ra_b,
        input  DO_a, DO_b, init_done
    );

    modport slave (
        input  rdy, we, wa, DI, ra_a, ra_b,
        output DO_a, DO_b, init_done
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - 1W/2R register file with init sequencer and zero register; optional forwarding under `REGFILE_BYPASS_EN
module regfile_mp #(
    parameter int DW       = 8,
    parameter int AW       = 5,
    parameter int ZERO_REG = 7
) (
    input logic        clk,
    input logic        reset,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] icnt, icnt_nx;
    logic [DW-1:0] regs [DEPTH];

    logic          init_wr;
    logic          port_wr;
    logic          wa_is_zero;
    logic          ra_a_is_zero;
    logic          ra_b_is_zero;

    // Power-up constants for the microcode: stack pointer, inc/dec helpers and vector-1 values.
    function automatic logic [DW-1:0] init_val(input int idx);
        logic [DW-1:0] v;
        case (idx)
            3:       v = {DW{1'b1}};
            5:       v = DW'(8'h01);
            6:       v = {DW{1'b1}};
            8:       v = DW'(8'hF9);
            9:       v = DW'(8'hFB);
            10:      v = DW'(8'hFD);
            default: v = '0;
        endcase
        return v;
    endfunction

    assign wa_is_zero   = (int'(bus.wa)   == ZERO_REG);
    assign ra_a_is_zero = (int'(bus.ra_a) == ZERO_REG);
    assign ra_b_is_zero = (int'(bus.ra_b) == ZERO_REG);

    assign init_wr   = (state == S_INIT);
    assign port_wr   = (state == S_RUN) && bus.we && bus.rdy && !wa_is_zero;
    assign bus.init_done = (state == S_RUN);

    // Sequencer state and init counter; reset restarts the init walk from entry 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
            icnt  <= '0;
        end else begin
            state <= state_nx;
            icnt  <= icnt_nx;
        end
    end

    // Walk every entry once, then park in RUN until the next reset.
    always_comb begin
        state_nx = state;
        icnt_nx  = icnt;
        case (state)
            S_INIT: begin
                icnt_nx = icnt + AW'(1);
                if (icnt == AW'(DEPTH - 1)) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                icnt_nx = icnt;
            end
            default: begin
                state_nx = S_INIT;
                icnt_nx  = '0;
            end
        endcase
    end

    // Array storage is not reset so contents survive a reset until the init walk overwrites them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_wr) begin
                regs[icnt] <= init_val(int'(icnt));
            end else if (port_wr) begin
                regs[bus.wa] <= bus.DI;
            end
        end
    end

    // Read port A: zero register wins, then optional same-cycle forward, then the array.
    always_comb begin
        bus.DO_a = regs[bus.ra_a];
`ifdef REGFILE_BYPASS_EN
        if (port_wr && (bus.ra_a == bus.wa)) begin
            bus.DO_a = bus.DI;
        end
`endif
        if (ra_a_is_zero) begin
            bus.DO_a = '0;
        end
    end

    // Read port B: same priority order as port A.
    always_comb begin
        bus.DO_b = regs[bus.ra_b];
`ifdef REGFILE_BYPASS_EN
        if (port_wr && (bus.ra_b == bus.wa)) begin
            bus.DO_b = bus.DI;
        end
`endif
        if (ra_b_is_zero) begin
            bus.DO_b = '0;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp with randomized traffic against an array model
module tb_regfile_mp;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int ZR    = 7;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_mp_if #(.DW(DW), .AW(AW)) bus ();

    regfile_mp #(.DW(DW), .AW(AW), .ZERO_REG(ZR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         passed = 0;
    int         total  = 0;
    logic [7:0] model [DEPTH];
    bit         in_run = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] init_const(input int i);
        case (i)
            3:       return 8'hFF;
            5:       return 8'h01;
            6:       return 8'hFF;
            8:       return 8'hF9;
            9:       return 8'hFB;
            10:      return 8'hFD;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_read(input logic [4:0] ra);
        if (ra == 5'(ZR)) return 8'h00;
`ifdef REGFILE_BYPASS_EN
        if (in_run && bus.we && bus.rdy && bus.wa != 5'(ZR) && bus.wa == ra) return bus.DI;
`endif
        return model[ra];
    endfunction

    task automatic drive(input logic w, input logic r, input logic [4:0] a,
                         input logic [7:0] d, input logic [4:0] x, input logic [4:0] y);
        bus.we   = w;
        bus.rdy  = r;
        bus.wa   = a;
        bus.DI   = d;
        bus.ra_a = x;
        bus.ra_b = y;
    endtask

    task automatic check_reads(input string tag);
        #1;
        chk({tag, "_a"}, 32'(bus.DO_a), 32'(exp_read(bus.ra_a)));
        chk({tag, "_b"}, 32'(bus.DO_b), 32'(exp_read(bus.ra_b)));
    endtask

    task automatic tick();
        @(posedge clk);
        if (in_run && bus.we && bus.rdy && bus.wa != 5'(ZR)) model[bus.wa] = bus.DI;
        @(negedge clk);
    endtask

    task automatic wait_init(input string tag);
        int cnt = 0;
        while (bus.init_done !== 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_init_cycles"}, 32'(cnt), 32'd32);
        for (int i = 0; i < DEPTH; i++) model[i] = init_const(i);
        in_run = 1'b1;
        @(negedge clk);
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 5'd0, 8'd0, 5'(i), 5'(DEPTH - 1 - i));
            check_reads(tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd0, 8'h77, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_init_done", 32'(bus.init_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_init("boot");
        drive(1'b0, 1'b1, 5'd0, 8'd0, 5'd0, 5'd0);
        readback("boot_rb");
        #1;
        chk("boot_reg0_no_init_write", 32'(bus.DO_a), 32'h00);

        drive(1'b1, 1'b1, 5'd2, 8'h41, 5'd2, 5'd2);
        check_reads("wr2_pre");
        tick();
        drive(1'b0, 1'b1, 5'd2, 8'h00, 5'd2, 5'd2);
        #1;
        chk("wr2_visible", 32'(bus.DO_a), 32'h41);
        drive(1'b1, 1'b0, 5'd2, 8'h55, 5'd2, 5'd2);
        tick();
        drive(1'b0, 1'b1, 5'd2, 8'h00, 5'd2, 5'd2);
        #1;
        chk("rdy_low_frozen", 32'(bus.DO_a), 32'h41);

        drive(1'b1, 1'b1, 5'd7, 8'hAA, 5'd7, 5'd7);
        check_reads("zero_pre");
        tick();
        drive(1'b0, 1'b1, 5'd0, 8'h00, 5'd7, 5'd7);
        #1;
        chk("zero_a", 32'(bus.DO_a), 32'h00);
        chk("zero_b", 32'(bus.DO_b), 32'h00);

        drive(1'b1, 1'b1, 5'd1, 8'h3C, 5'd0, 5'd1);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same_cycle", 32'(bus.DO_b), 32'h3C);
`else
        chk("no_bypass_old", 32'(bus.DO_b), 32'h00);
`endif
        tick();
        drive(1'b0, 1'b1, 5'd0, 8'h00, 5'd1, 5'd1);
        #1;
        chk("wr1_after_edge", 32'(bus.DO_b), 32'h3C);

        for (int n = 0; n < 250; n++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, DEPTH - 1));
            drive(1'($urandom), 1'($urandom_range(0, 3) != 0), a, 8'($urandom),
                  ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, DEPTH - 1)),
                  ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, DEPTH - 1)));
            check_reads("rand");
            tick();
        end

        drive(1'b0, 1'b1, 5'd0, 8'd0, 5'd0, 5'd0);
        tick();
        @(posedge clk);
        #2;
        reset = 1'b1;
        in_run = 1'b0;
        #1;
        chk("run_reset_async", 32'(bus.init_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b1, 5'd0, 8'h77, 5'd0, 5'd0);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midinit_reset", 32'(bus.init_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_init("reinit");
        drive(1'b0, 1'b1, 5'd0, 8'd0, 5'd0, 5'd0);
        readback("reinit_rb");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
